// File: rtl/johnson_decoder.sv
// johnson_decoder: receive-side checker for a 2N-state Johnson counter code.
// Decodes each sampled word to a binary index and a one-hot vector, flags
// illegal and out-of-sequence words, tracks lock to the counter and keeps a
// saturating error count.
// Optional feature macro: JOHNSON_DEC_HOLD_EN (a repeated index is a legal
// counter stall instead of a sequence break).
module johnson_decoder #(
  parameter int unsigned N        = 4,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned ERR_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0]              code_in,
  input  logic                      code_valid,
  input  logic                      err_clr,
  output logic [$clog2(2*N)-1:0]    bin_out,
  output logic [2*N-1:0]            onehot_out,
  output logic                      dec_valid,
  output logic                      illegal,
  output logic                      seq_err,
  output logic                      locked,
  output logic [ERR_W-1:0]          err_cnt
);

  localparam int unsigned S  = 2 * N;
  localparam int unsigned BW = $clog2(S);
  localparam int unsigned LW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

`ifdef JOHNSON_DEC_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     lcnt_q, lcnt_d;
  logic              has_ref_q, has_ref_d;
  logic [BW-1:0]     bin_d;
  logic [S-1:0]      onehot_d;
  logic              dv_d, ill_d, seq_d;
  logic [ERR_W-1:0]  err_cnt_d;

  logic              legal_c;
  logic [BW-1:0]     idx_c;
  logic [BW-1:0]     expect_c;
  logic              hold_c;
  logic              err_c;
  int unsigned       trans_c;
  int unsigned       pop_c;

  // Combinational decode: a legal word has at most one adjacent-bit transition
  always_comb begin
    trans_c = 0;
    pop_c   = 0;
    for (int unsigned i = 0; i + 1 < N; i++) begin
      trans_c = trans_c + 32'(code_in[i] ^ code_in[i+1]);
    end
    for (int unsigned i = 0; i < N; i++) begin
      pop_c = pop_c + 32'(code_in[i]);
    end
    legal_c  = (trans_c <= 1);
    idx_c    = (code_in[N-1] || (pop_c == 0)) ? BW'(pop_c) : BW'(S - pop_c);
    expect_c = (bin_out == BW'(S - 1)) ? '0 : bin_out + BW'(1);
    hold_c   = HOLD_EN && has_ref_q && (idx_c == bin_out);
  end

  // Next-state and next-output logic for the lock FSM and flags
  always_comb begin
    state_d   = state_q;
    lcnt_d    = lcnt_q;
    has_ref_d = has_ref_q;
    bin_d     = bin_out;
    onehot_d  = '0;
    dv_d      = 1'b0;
    ill_d     = 1'b0;
    seq_d     = 1'b0;
    err_c     = 1'b0;

    if (code_valid) begin
      if (!legal_c) begin
        ill_d     = 1'b1;
        err_c     = 1'b1;
        state_d   = UNLOCKED;
        lcnt_d    = '0;
        has_ref_d = 1'b0;
      end else begin
        dv_d      = 1'b1;
        bin_d     = idx_c;
        onehot_d  = S'(1) << idx_c;
        has_ref_d = 1'b1;
        if (hold_c) begin
          // counter stalled: nothing else changes
        end else if (has_ref_q && (idx_c == expect_c)) begin
          if (state_q == UNLOCKED) begin
            if (32'(lcnt_q) + 1 >= LOCK_CNT) state_d = LOCKED;
            if (32'(lcnt_q) < LOCK_CNT) lcnt_d = lcnt_q + LW'(1);
          end
        end else begin
          lcnt_d = LW'(1);
          if (state_q == LOCKED) begin
            seq_d   = 1'b1;
            err_c   = 1'b1;
            state_d = UNLOCKED;
          end else begin
            state_d = (LOCK_CNT <= 1) ? LOCKED : UNLOCKED;
          end
        end
      end
    end

    if (err_clr)                    err_cnt_d = ERR_W'(err_c);
    else if (err_c && ~&err_cnt)    err_cnt_d = err_cnt + ERR_W'(1);
    else                            err_cnt_d = err_cnt;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= UNLOCKED;
      lcnt_q     <= '0;
      has_ref_q  <= 1'b0;
      bin_out    <= '0;
      onehot_out <= '0;
      dec_valid  <= 1'b0;
      illegal    <= 1'b0;
      seq_err    <= 1'b0;
      locked     <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      lcnt_q     <= lcnt_d;
      has_ref_q  <= has_ref_d;
      bin_out    <= bin_d;
      onehot_out <= onehot_d;
      dec_valid  <= dv_d;
      illegal    <= ill_d;
      seq_err    <= seq_d;
      locked     <= (state_d == LOCKED);
      err_cnt    <= err_cnt_d;
    end
  end

endmodule
